// File: rtl/cover_toggle_reporter_pkg.sv
// Shared types and helpers for the toggle-coverage reporter: index width,
// popcount and the (bit, direction) to point-number mapping.
package cover_toggle_pkg;

    localparam int IDX_W   = 64;
    localparam int MAX_PTS = 1024;
    localparam int POP_W   = $clog2(MAX_PTS + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_PTS-1:0] vec);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_PTS; i++) begin
            n = n + POP_W'(vec[i]);
        end
        return n;
    endfunction

    // dir = 0 for a rising edge, 1 for a falling edge
    function automatic int unsigned point_num(input int unsigned bit_idx, input logic dir);
        return 2 * bit_idx + 32'(dir);
    endfunction

endpackage

// File: rtl/cover_toggle_reporter_pick_lowest.sv
// Lowest-set-bit priority encoder used to pick the next pending coverage point.
module cover_pick_lowest #(
    parameter int N = 52,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cover_toggle_reporter.sv
// Toggle-coverage source: records the first rise and fall of each observed bit
// and streams every newly covered point once as a global coverage index.
module cover_toggle_reporter
    import cover_toggle_pkg::*;
#(
    parameter int unsigned WIDTH       = 26,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = 28338,
    localparam int unsigned NPTS       = 2 * WIDTH,
    localparam int CNT_W               = $clog2(NPTS + 1)
) (
    input  logic             gbl_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig,
    input  logic             en,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] covered_cnt,
    output logic             all_covered
);

    localparam int PW = (NPTS > 1) ? $clog2(NPTS) : 1;

    if (COVER_INDEX + NPTS > COVER_TOTAL) begin : g_range_err
        $error("cover_toggle_reporter: COVER_INDEX + NPTS exceeds COVER_TOTAL");
    end
    if (NPTS > MAX_PTS) begin : g_size_err
        $error("cover_toggle_reporter: NPTS exceeds MAX_PTS of cover_toggle_pkg");
    end

    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic [NPTS-1:0]  covered;
    logic [NPTS-1:0]  pending;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             edge_ok;
    logic [NPTS-1:0]  detected;
    logic [NPTS-1:0]  newly;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;
    logic             pick_any;
    logic [PW-1:0]    pick_idx;
    logic             load;
    logic [NPTS-1:0]  load_mask;

    assign edge_ok = en & prev_valid;
    assign rise    = sig & ~prev;
    assign fall    = ~sig & prev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_points
        localparam int unsigned PR = point_num(i, 1'b0);
        localparam int unsigned PF = point_num(i, 1'b1);
        assign detected[PR] = rise[i] & edge_ok;
        assign detected[PF] = fall[i] & edge_ok;
    end

    assign newly = detected & ~covered;

    always_comb begin
        cnt_sum = {1'b0, covered_cnt} + (CNT_W + 1)'(popcount(MAX_PTS'(newly)));
        if (cnt_sum > (CNT_W + 1)'(NPTS)) begin
            cnt_next = CNT_W'(NPTS);
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    cover_pick_lowest #(
        .N (NPTS)
    ) u_pick (
        .vec (pending),
        .any (pick_any),
        .idx (pick_idx)
    );

    // The output register refills from pending only when the current beat is
    // free or leaving this cycle; a clear cycle never refills.
    assign load      = pick_any & ~clear & (~out_valid | out_ready);
    assign load_mask = load ? (NPTS'(1) << pick_idx) : '0;

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            prev        <= '0;
            prev_valid  <= 1'b0;
            covered     <= '0;
            pending     <= '0;
            covered_cnt <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
        end else begin
            if (en) begin
                prev       <= sig;
                prev_valid <= 1'b1;
            end

            if (clear) begin
                covered     <= '0;
                pending     <= '0;
                covered_cnt <= '0;
            end else begin
                covered     <= covered | newly;
                pending     <= (pending & ~load_mask) | newly;
                covered_cnt <= cnt_next;
            end

            if (load) begin
                out_valid <= 1'b1;
                out_index <= IDX_W'(COVER_INDEX) + IDX_W'(pick_idx);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign all_covered = (covered_cnt == CNT_W'(NPTS));

endmodule

// File: tb/tb_cover_toggle_reporter.sv
// Bench for cover_toggle_reporter: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_cover_toggle_reporter;

    localparam int W     = 26;
    localparam int NPTS  = 2 * W;
    localparam int CI    = 100;
    localparam int CNT_W = $clog2(NPTS + 1);

    logic             gbl_clk;
    logic             reset;
    logic [W-1:0]     sig;
    logic             en;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_index;
    logic [CNT_W-1:0] covered_cnt;
    logic             all_covered;

    cover_toggle_reporter #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .COVER_TOTAL (28338)
    ) dut (
        .gbl_clk     (gbl_clk),
        .reset       (reset),
        .sig         (sig),
        .en          (en),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .covered_cnt (covered_cnt),
        .all_covered (all_covered)
    );

    initial gbl_clk = 1'b0;
    always #5 gbl_clk = ~gbl_clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: coverage as a bit set, pending as a sorted queue of points
    logic [W-1:0]    m_prev;
    bit              m_pv;
    bit [NPTS-1:0]   m_cov;
    int              m_pend[$];
    bit              m_valid;
    longint unsigned m_idx;
    int              m_cnt;

    bit record;
    int beat_seen[NPTS];

    typedef struct {
        logic            rst;
        logic [W-1:0]    s;
        logic            e;
        logic            c;
        logic            r;
        logic            ev;
        longint unsigned ei;
        int              ec;
    } vec_t;

    vec_t tbl[$];

    task automatic check_eq(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst_a, input logic [W-1:0] s, input logic e, input logic c,
                              input logic r);
        int  found[$];
        bit  load;
        if (rst_a) begin
            m_prev  = '0;
            m_pv    = 0;
            m_cov   = '0;
            m_pend.delete();
            m_valid = 0;
            m_idx   = 0;
            m_cnt   = 0;
            return;
        end
        if (e && m_pv) begin
            for (int i = 0; i < W; i++) begin
                if (s[i] && !m_prev[i]) found.push_back(2 * i);
                if (!s[i] && m_prev[i]) found.push_back(2 * i + 1);
            end
        end
        load = !c && (m_pend.size() > 0) && (!m_valid || r);
        if (load) begin
            m_idx   = CI + m_pend.pop_front();
            m_valid = 1;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        if (c) begin
            m_cov = '0;
            m_pend.delete();
            m_cnt = 0;
        end else begin
            foreach (found[k]) begin
                if (!m_cov[found[k]]) begin
                    m_cov[found[k]] = 1;
                    m_pend.push_back(found[k]);
                    m_cnt++;
                end
            end
            m_pend.sort();
            if (m_cnt > NPTS) m_cnt = NPTS;
        end
        if (e) begin
            m_prev = s;
            m_pv   = 1;
        end
    endtask

    task automatic check_output();
        check_eq("valid", out_valid, m_valid);
        if (m_valid) check_eq("index", out_index, m_idx);
        check_eq("cnt", covered_cnt, m_cnt);
        check_eq("all_covered", all_covered, m_cnt == NPTS);
    endtask

    // Drives one cycle of inputs, advances DUT and model together, then compares
    task automatic apply_stimulus(input logic rst_a, input logic [W-1:0] s, input logic e, input logic c,
                                  input logic r);
        reset     = !rst_a;
        sig       = s;
        en        = e;
        clear     = c;
        out_ready = r;
        #1;
        if (record && !rst_a && out_valid && out_ready && out_index >= CI && out_index < CI + NPTS)
            beat_seen[out_index - CI]++;
        @(posedge gbl_clk);
        model_edge(rst_a, s, e, c, r);
        @(negedge gbl_clk);
        check_output();
    endtask

    task automatic add_vec(input logic rst, input logic [W-1:0] s, input logic e, input logic c, input logic r,
                           input logic ev, input longint unsigned ei, input int ec);
        vec_t v;
        v.rst = rst; v.s = s; v.e = e; v.c = c; v.r = r;
        v.ev = ev; v.ei = ei; v.ec = ec;
        tbl.push_back(v);
    endtask

    initial begin
        logic [W-1:0] all_ones;
        logic [W-1:0] rs;
        logic [W-1:0] flips;
        all_ones = '1;
        record   = 0;
        reset = 1'b0; sig = '0; en = 1'b0; clear = 1'b0; out_ready = 1'b0;

        apply_stimulus(1, '0, 1, 0, 1);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_index", out_index, 0);
        check_eq("rst_cnt", covered_cnt, 0);

        // Single rise on bit 0, two-edge latency
        add_vec(0, 26'h0, 1, 0, 1, 0, 0, 0);
        add_vec(0, 26'h0, 1, 0, 1, 0, 0, 0);
        add_vec(0, 26'h0, 1, 0, 1, 0, 0, 0);
        add_vec(0, 26'h1, 1, 0, 1, 0, 0, 1);
        add_vec(0, 26'h1, 1, 0, 1, 1, CI + 0, 1);
        add_vec(0, 26'h1, 1, 0, 1, 0, 0, 1);
        // Clear, then bit 3 toggles: second rise is not reported again
        add_vec(0, 26'h1, 1, 1, 1, 0, 0, 0);
        add_vec(0, 26'h9, 1, 0, 1, 0, 0, 1);
        add_vec(0, 26'h1, 1, 0, 1, 1, CI + 6, 2);
        add_vec(0, 26'h9, 1, 0, 1, 1, CI + 7, 2);
        add_vec(0, 26'h9, 1, 0, 1, 0, 0, 2);
        add_vec(0, 26'h9, 1, 0, 1, 0, 0, 2);
        // Edges in a clear cycle are dropped; then two rises with backpressure
        add_vec(0, 26'h0, 1, 1, 1, 0, 0, 0);
        add_vec(0, 26'h3, 1, 0, 0, 0, 0, 2);
        for (int k = 0; k < 5; k++) add_vec(0, 26'h3, 1, 0, 0, 1, CI + 0, 2);
        add_vec(0, 26'h3, 1, 0, 1, 1, CI + 2, 2);
        add_vec(0, 26'h3, 1, 0, 1, 0, 0, 2);
        // Clear while a beat is held and another point is pending
        add_vec(0, 26'h0, 1, 0, 0, 0, 0, 4);
        add_vec(0, 26'h0, 1, 0, 0, 1, CI + 1, 4);
        add_vec(0, 26'h0, 1, 1, 0, 1, CI + 1, 0);
        add_vec(0, 26'h0, 1, 0, 1, 0, 0, 0);
        add_vec(0, 26'h1, 1, 0, 1, 0, 0, 1);
        add_vec(0, 26'h1, 1, 0, 1, 1, CI + 0, 1);
        add_vec(0, 26'h1, 1, 0, 1, 0, 0, 1);

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i].rst, tbl[i].s, tbl[i].e, tbl[i].c, tbl[i].r);
            check_eq("tbl_valid", out_valid, tbl[i].ev);
            if (tbl[i].ev) check_eq("tbl_index", out_index, tbl[i].ei);
            check_eq("tbl_cnt", covered_cnt, tbl[i].ec);
        end

        // First enabled sample after reset is all ones: loads prev only
        apply_stimulus(1, all_ones, 1, 0, 1);
        foreach (beat_seen[p]) beat_seen[p] = 0;
        record = 1;
        apply_stimulus(0, all_ones, 1, 0, 1);
        apply_stimulus(0, all_ones, 1, 0, 1);
        check_eq("first_sample_valid", out_valid, 0);
        check_eq("first_sample_cnt", covered_cnt, 0);
        // Disabled samples neither detect edges nor move prev
        apply_stimulus(0, '0, 0, 0, 1);
        apply_stimulus(0, '0, 0, 0, 1);
        check_eq("en_low_cnt", covered_cnt, 0);
        apply_stimulus(0, '0, 1, 0, 1);
        check_eq("all_fall_cnt", covered_cnt, W);
        apply_stimulus(0, all_ones, 1, 0, 1);
        check_eq("all_toggle_cnt", covered_cnt, NPTS);
        check_eq("all_toggle_flag", all_covered, 1);
        for (int k = 0; k < NPTS + 8; k++) apply_stimulus(0, all_ones, 1, 0, 1);
        check_eq("drain_valid", out_valid, 0);
        for (int p = 0; p < NPTS; p++) check_eq($sformatf("beat_once_%0d", CI + p), beat_seen[p], 1);
        record = 0;

        // Randomized traffic against the model, with occasional clears and resets
        apply_stimulus(1, '0, 1, 0, 1);
        rs = '0;
        for (int k = 0; k < 3000; k++) begin
            flips = '0;
            for (int b = 0; b < W; b++) if ($urandom_range(15) == 0) flips[b] = 1'b1;
            rs = rs ^ flips;
            apply_stimulus($urandom_range(299) == 0, rs, $urandom_range(9) != 0,
                           $urandom_range(39) == 0, $urandom_range(9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
